// File: rtl/ariane_axi.sv
`default_nettype none
// ============================================================================
// Package     : ariane_axi
// Description : AXI4 channel and request/response bundle types shared by the
//               cache subsystem and the memory interconnect.
// Revision    : 1.0 - initial release
// ============================================================================
package ariane_axi;

    localparam int unsigned ID_WIDTH   = 4;
    localparam int unsigned ADDR_WIDTH = 64;
    localparam int unsigned DATA_WIDTH = 64;
    localparam int unsigned USER_WIDTH = 1;

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [ADDR_WIDTH-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
        logic                  lock;
        logic [3:0]            cache;
        logic [2:0]            prot;
        logic [3:0]            qos;
        logic [3:0]            region;
        logic [5:0]            atop;
        logic [USER_WIDTH-1:0] user;
    } aw_chan_t;

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [ADDR_WIDTH-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
        logic                  lock;
        logic [3:0]            cache;
        logic [2:0]            prot;
        logic [3:0]            qos;
        logic [3:0]            region;
        logic [USER_WIDTH-1:0] user;
    } ar_chan_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]   data;
        logic [DATA_WIDTH/8-1:0] strb;
        logic                    last;
        logic [USER_WIDTH-1:0]   user;
    } w_chan_t;

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [1:0]            resp;
        logic [USER_WIDTH-1:0] user;
    } b_chan_t;

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [DATA_WIDTH-1:0] data;
        logic [1:0]            resp;
        logic                  last;
        logic [USER_WIDTH-1:0] user;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } resp_t;

endpackage
`default_nettype wire

// File: rtl/cache_axi_txn_limiter.sv
`default_nettype none
// ============================================================================
// Module      : cache_axi_txn_limiter
// Description : Zero-latency AXI pass-through that caps outstanding read and
//               write bursts, holds W until its AW has been accepted, and can
//               drain all outstanding traffic on request.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_axi_txn_limiter #(
    parameter int unsigned MaxRdTxn = 4,
    parameter int unsigned MaxWrTxn = 4,
    parameter int unsigned CntWidth = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  drain_i,
    input  ariane_axi::req_t      slv_req_i,
    output ariane_axi::resp_t     slv_resp_o,
    output ariane_axi::req_t      mst_req_o,
    input  ariane_axi::resp_t     mst_resp_i,
    output logic [CntWidth-1:0]   rd_cnt_o,
    output logic [CntWidth-1:0]   wr_cnt_o,
    output logic                  drained_o,
    output logic                  err_o
);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    localparam logic [CntWidth-1:0] C_MAX_RD = CntWidth'(MaxRdTxn);
    localparam logic [CntWidth-1:0] C_MAX_WR = CntWidth'(MaxWrTxn);

    state_t              r_state;
    state_t              w_state_next;
    logic [CntWidth-1:0] r_rd_cnt;
    logic [CntWidth-1:0] r_wr_cnt;
    logic [CntWidth-1:0] r_w_pend;
    logic                r_err;

    logic w_ar_en;
    logic w_aw_en;
    logic w_w_en;
    logic w_ar_hs;
    logic w_aw_hs;
    logic w_w_last_hs;
    logic w_r_last_hs;
    logic w_b_hs;
    logic w_err_set;

    // Saturating up/down step: simultaneous inc and dec cancel, and a
    // decrement at zero is absorbed (it is reported separately as an error).
    function automatic logic [CntWidth-1:0] f_cnt_next(
        input logic [CntWidth-1:0] cnt,
        input logic                inc,
        input logic                dec
    );
        if (inc && !dec) begin
            return cnt + CntWidth'(1);
        end else if (dec && !inc && (cnt != '0)) begin
            return cnt - CntWidth'(1);
        end else begin
            return cnt;
        end
    endfunction

    // Gate enables derive from registered state only, so no comb loop is
    // formed through the ready/valid pairs.
    assign w_ar_en = (r_rd_cnt < C_MAX_RD) && (r_state == ST_RUN);
    assign w_aw_en = (r_wr_cnt < C_MAX_WR) && (r_state == ST_RUN);
    assign w_w_en  = (r_w_pend != '0);

    // Pass everything straight through, then override the gated handshakes.
    always_comb begin
        mst_req_o           = slv_req_i;
        mst_req_o.ar_valid  = slv_req_i.ar_valid & w_ar_en;
        mst_req_o.aw_valid  = slv_req_i.aw_valid & w_aw_en;
        mst_req_o.w_valid   = slv_req_i.w_valid  & w_w_en;
        slv_resp_o          = mst_resp_i;
        slv_resp_o.ar_ready = mst_resp_i.ar_ready & w_ar_en;
        slv_resp_o.aw_ready = mst_resp_i.aw_ready & w_aw_en;
        slv_resp_o.w_ready  = mst_resp_i.w_ready  & w_w_en;
    end

    assign w_ar_hs     = mst_req_o.ar_valid & mst_resp_i.ar_ready;
    assign w_aw_hs     = mst_req_o.aw_valid & mst_resp_i.aw_ready;
    assign w_w_last_hs = mst_req_o.w_valid  & mst_resp_i.w_ready & slv_req_i.w.last;
    assign w_r_last_hs = mst_resp_i.r_valid & slv_req_i.r_ready  & mst_resp_i.r.last;
    assign w_b_hs      = mst_resp_i.b_valid & slv_req_i.b_ready;

    // Any completion with nothing outstanding is a protocol violation.
    assign w_err_set = (w_r_last_hs && (r_rd_cnt == '0))
                     || (w_b_hs      && (r_wr_cnt == '0))
                     || (w_w_last_hs && (r_w_pend == '0));

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: drain_i is a level request in both directions.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN:   if (drain_i)  w_state_next = ST_DRAIN;
            ST_DRAIN: if (!drain_i) w_state_next = ST_RUN;
            default:  w_state_next = ST_RUN;
        endcase
    end

    // Outstanding-burst counters and sticky error flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
            r_w_pend <= '0;
            r_err    <= 1'b0;
        end else begin
            r_rd_cnt <= f_cnt_next(r_rd_cnt, w_ar_hs, w_r_last_hs);
            r_wr_cnt <= f_cnt_next(r_wr_cnt, w_aw_hs, w_b_hs);
            r_w_pend <= f_cnt_next(r_w_pend, w_aw_hs, w_w_last_hs);
            r_err    <= r_err | w_err_set;
        end
    end

    assign rd_cnt_o  = r_rd_cnt;
    assign wr_cnt_o  = r_wr_cnt;
    assign err_o     = r_err;
    assign drained_o = (r_state == ST_DRAIN) && (r_rd_cnt == '0)
                     && (r_wr_cnt == '0) && (r_w_pend == '0);

endmodule
`default_nettype wire

// File: doc/cache_axi_txn_limiter.md
CACHE_AXI_TXN_LIMITER -- requirements
Module: cache_axi_txn_limiter

Interface
REQ-001 SHALL have parameter MaxRdTxn, default 4, maximum outstanding read bursts (AR accepted, R last not yet seen).
REQ-002 SHALL have parameter MaxWrTxn, default 4, maximum outstanding write bursts (AW accepted, B not yet seen).
REQ-003 SHALL have parameter CntWidth, default 3, counter width; must satisfy 2^CntWidth > max(MaxRdTxn, MaxWrTxn).
REQ-004 clk_i  in  1  sole clock, rising edge.
REQ-005 rst_i  in  1  reset, synchronous, active-high.
REQ-006 drain_i  in  1  level request: stop issuing new AR/AW and empty the outstanding counts.
REQ-007 slv_req_i  in  ariane_axi::req_t  request from the cache subsystem AXI master port.
REQ-008 slv_resp_o  out  ariane_axi::resp_t  response to the cache subsystem.
REQ-009 mst_req_o  out  ariane_axi::req_t  request to the memory interconnect.
REQ-010 mst_resp_i  in  ariane_axi::resp_t  response from the memory interconnect.
REQ-011 rd_cnt_o  out  CntWidth  current outstanding read count.
REQ-012 wr_cnt_o  out  CntWidth  current outstanding write count.
REQ-013 drained_o  out  1  high when in DRAIN and both counts are 0.
REQ-014 err_o  out  1  sticky protocol-error flag.

Function
REQ-015 All payload fields (ar, aw, w, r, b) SHALL pass through combinationally and unmodified. Zero added latency on any channel.
REQ-016 mst_req_o.ar_valid SHALL be slv_req_i.ar_valid AND ar_en, where ar_en = (rd_cnt < MaxRdTxn) AND state==RUN. slv_resp_o.ar_ready SHALL be mst_resp_i.ar_ready AND ar_en.
REQ-017 The AW channel SHALL be gated the same way using wr_cnt, MaxWrTxn and aw_en.
REQ-018 W beats SHALL be forwarded only while w_pend > 0. w_pend counts AW handshakes whose W burst has not yet completed, using registered values only. A W beat in the same cycle as its AW handshake SHALL be stalled one cycle.
REQ-019 R, B valid/ready and all ready signals not named above SHALL pass straight through.
REQ-020 rd_cnt: +1 on AR handshake; -1 on an R handshake with r.last. Both in the same cycle: unchanged.
REQ-021 wr_cnt: +1 on AW handshake; -1 on a B handshake. Both in the same cycle: unchanged.
REQ-022 w_pend: +1 on AW handshake; -1 on a W handshake with w.last. Both in the same cycle: unchanged.
REQ-023 Counters SHALL never wrap. A decrement event at count 0 SHALL leave the count at 0 and set err_o. err_o SHALL be cleared only by reset.
REQ-024 FSM states: RUN, DRAIN.
 - RUN -> DRAIN when drain_i=1.
 - DRAIN -> RUN when drain_i=0.
 - While in DRAIN, no new AR/AW is forwarded, while R/W/B continue to flow.
REQ-025 An AR/AW with valid high and not yet handshaken when entering DRAIN SHALL be held off (ready=0). The upstream valid stays asserted per AXI rules and is not dropped.
REQ-026 drained_o SHALL be combinational from the registered state and counts: (state==DRAIN) AND rd_cnt==0 AND wr_cnt==0 AND w_pend==0.
REQ-027 At a count equal to its maximum, the matching valid SHALL be masked. It SHALL unmask in the cycle after the decrement registers.

Reset
REQ-028 On rst_i=1 at a clock edge, the following SHALL reset:
 - rd_cnt, wr_cnt, w_pend = 0
 - state = RUN
 - err_o = 0
 This gives drained_o = 0, with gated valids following REQ-016/017.
REQ-029 Reset asserted mid-burst SHALL discard all tracking with no error flagged. Resetting the interconnect alongside this block is the integrator's responsibility.

Verification
REQ-030 Default params: 5 back-to-back ARs with ar_ready=1 -> 4 forwarded in cycles 0-3, rd_cnt=4, 5th stalled. R last returned -> rd_cnt drops to 3, and the 5th AR is forwarded the cycle after.
REQ-031 AW and W valid both asserted in cycle 0 -> AW forwarded in cycle 0, first W forwarded in cycle 1. A 4-beat burst -> w_pend returns to 0 after the last beat; a B -> wr_cnt=0.
REQ-032 rd_cnt=2, and AR handshake plus R last in the same cycle -> rd_cnt stays 2, err_o=0.
REQ-033 rd_cnt=1, wr_cnt=1, drain_i=1 plus a new AR pending -> AR held off. After R last and B, drained_o=1 with all counts 0. Then drain_i=0 -> AR forwarded the next cycle.
REQ-034 B handshake with wr_cnt=0 -> wr_cnt stays 0, err_o=1 and stays 1 until rst_i. rst_i with rd_cnt=3 -> all counts 0 the next cycle.
